// File: rtl/wb_queue_if.sv
// Handshake/bus bundle for the wb_queue write-back stage: MEM-side push, register-file drain,
// forwarding lookup and retire counter.
interface wb_queue_if #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_regsrc;
  logic [DATA_W-1:0]  in_pc_plus_two;
  logic [DATA_W-1:0]  in_mem_data;
  logic [DATA_W-1:0]  in_alu;
  logic [DATA_W-1:0]  in_const;
  logic               in_wr_en;
  logic [RADDR_W-1:0] in_wr_addr;
  logic               flush;
  logic               rf_ready;
  logic               rf_wr_en;
  logic [RADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0]  rf_wr_data;
  logic [RADDR_W-1:0] fwd_addr;
  logic               fwd_hit;
  logic [DATA_W-1:0]  fwd_data;
  logic [15:0]        retire_cnt;

  modport master (
    output in_valid, in_regsrc, in_pc_plus_two, in_mem_data, in_alu, in_const,
           in_wr_en, in_wr_addr, flush, rf_ready, fwd_addr,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_hit, fwd_data, retire_cnt
  );

  modport slave (
    input  in_valid, in_regsrc, in_pc_plus_two, in_mem_data, in_alu, in_const,
           in_wr_en, in_wr_addr, flush, rf_ready, fwd_addr,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data, fwd_hit, fwd_data, retire_cnt
  );
endinterface

// File: rtl/wb_queue.sv
// Write-back stage: RegSrc select into an in-order DEPTH-entry buffer drained to the register file,
// with forwarding over pending entries. Optional retire counter under WB_RETIRE_CNT_EN.
module wb_queue #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int DEPTH   = 2
) (
  input  logic     clk,
  input  logic     rst,
  wb_queue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [RADDR_W-1:0] addr;
    logic               wen;
  } ent_t;

  ent_t [DEPTH-1:0] mem_q;
  ent_t             head;
  logic [PW-1:0]    rd_ptr, wr_ptr, idx;
  logic [PW:0]      occ;
  logic             empty, full, push, pop;
  logic [DATA_W-1:0] sel_data;

  assign empty        = (occ == '0);
  assign full         = (occ == (PW+1)'(DEPTH));
  assign bus.in_ready = ~full & ~bus.flush;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~empty & bus.rf_ready;

  always_comb begin
    sel_data = bus.in_pc_plus_two;
    case (bus.in_regsrc)
      2'b01:   sel_data = bus.in_mem_data;
      2'b10:   sel_data = bus.in_alu;
      2'b11:   sel_data = bus.in_const;
      default: sel_data = bus.in_pc_plus_two;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates every use of an entry.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= '{data: sel_data, addr: bus.in_wr_addr, wen: bus.in_wr_en};
  end

  assign head           = mem_q[rd_ptr];
  assign bus.rf_wr_en   = pop & head.wen;
  assign bus.rf_wr_addr = empty ? '0 : head.addr;
  assign bus.rf_wr_data = empty ? '0 : head.data;

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    idx          = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (((PW+1)'(k) < occ) && mem_q[idx].wen && (mem_q[idx].addr == bus.fwd_addr)) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = mem_q[idx].data;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 16'd1;
  end
  assign bus.retire_cnt = cnt_q;
`else
  assign bus.retire_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table, randomized run against a queue model,
// and retire-counter sequences.
module tb_wb_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_queue_if #(.DATA_W(16), .RADDR_W(3)) bus();
  wb_queue #(.DATA_W(16), .RADDR_W(3), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  localparam int DEPTH = 2;
  int errs = 0, checks = 0;

  typedef struct {
    logic rst, vld; logic [1:0] src; logic wen; logic [2:0] wa; logic [15:0] val;
    logic fl, rfr; logic [2:0] fa;
    logic e_rdy, e_wen; logic [2:0] e_wa; logic [15:0] e_wd; logic e_hit; logic [15:0] e_fd;
  } vec_t;

  typedef struct { logic [15:0] d; logic [2:0] a; logic w; } ent_t;
  ent_t q[$];
  logic [15:0] mcnt;

  function automatic vec_t mk(logic r, logic v, logic [1:0] s, logic w, logic [2:0] wa,
                              logic [15:0] val, logic fl, logic rfr, logic [2:0] fa,
                              logic erdy, logic ewen, logic [2:0] ewa, logic [15:0] ewd,
                              logic ehit, logic [15:0] efd);
    vec_t t;
    t.rst = r; t.vld = v; t.src = s; t.wen = w; t.wa = wa; t.val = val; t.fl = fl; t.rfr = rfr;
    t.fa = fa; t.e_rdy = erdy; t.e_wen = ewen; t.e_wa = ewa; t.e_wd = ewd; t.e_hit = ehit;
    t.e_fd = efd;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The unselected sources carry the complement so a wrong select is visible.
  task automatic drive(logic r, logic v, logic [1:0] s, logic w, logic [2:0] wa,
                       logic [15:0] val, logic fl, logic rfr, logic [2:0] fa);
    rst = r; bus.in_valid = v; bus.in_regsrc = s; bus.in_wr_en = w; bus.in_wr_addr = wa;
    bus.in_pc_plus_two = ~val; bus.in_mem_data = ~val; bus.in_alu = ~val; bus.in_const = ~val;
    case (s)
      2'd0: bus.in_pc_plus_two = val;
      2'd1: bus.in_mem_data = val;
      2'd2: bus.in_alu = val;
      default: bus.in_const = val;
    endcase
    bus.flush = fl; bus.rf_ready = rfr; bus.fwd_addr = fa;
  endtask

  // One cycle against the model: inputs already driven at the negedge.
  task automatic cyc();
    logic erdy, ehit, pop, push; logic [15:0] efd, seldata; logic [15:0] ecnt;
    #1;
    erdy = (q.size() < DEPTH) && !bus.flush;
    ehit = 1'b0; efd = '0;
    foreach (q[i]) if (q[i].w && q[i].a == bus.fwd_addr) begin ehit = 1'b1; efd = q[i].d; end
`ifdef WB_RETIRE_CNT_EN
    ecnt = mcnt;
`else
    ecnt = 16'h0;
`endif
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, erdy});
    chk("rf_wr_en", {31'b0, bus.rf_wr_en},
        {31'b0, (q.size() > 0) && q[0].w && bus.rf_ready});
    chk("rf_wr_addr", {29'b0, bus.rf_wr_addr}, (q.size() > 0) ? {29'b0, q[0].a} : 32'h0);
    chk("rf_wr_data", {16'b0, bus.rf_wr_data}, (q.size() > 0) ? {16'b0, q[0].d} : 32'h0);
    chk("fwd_hit", {31'b0, bus.fwd_hit}, {31'b0, ehit});
    chk("fwd_data", {16'b0, bus.fwd_data}, {16'b0, efd});
    chk("retire_cnt", {16'b0, bus.retire_cnt}, {16'b0, ecnt});
    pop  = (q.size() > 0) && bus.rf_ready;
    push = bus.in_valid && erdy;
    case (bus.in_regsrc)
      2'd0: seldata = bus.in_pc_plus_two;
      2'd1: seldata = bus.in_mem_data;
      2'd2: seldata = bus.in_alu;
      default: seldata = bus.in_const;
    endcase
    if (rst) begin
      q.delete(); mcnt = 0;
    end else begin
      if (pop) begin void'(q.pop_front()); mcnt = mcnt + 16'd1; end
      if (bus.flush) q.delete();
      else if (push) q.push_back('{d: seldata, a: bus.in_wr_addr, w: bus.in_wr_en});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    q.delete(); mcnt = 0;
    rst = 1'b0;
  endtask

  vec_t tv[$];

  initial begin
    @(negedge clk);
    do_reset();

    // Source select, rf_ready=1
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,0,1,1,16'h0002,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,1,1,2,16'h1111,0,1,0, 1,1,1,16'h0002,0,16'h0000));
    tv.push_back(mk(0,1,2,1,3,16'h2222,0,1,0, 1,1,2,16'h1111,0,16'h0000));
    tv.push_back(mk(0,1,3,1,4,16'h3333,0,1,0, 1,1,3,16'h2222,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,1,4,16'h3333,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    // Backpressure; third push offered while full is dropped
    tv.push_back(mk(0,1,2,1,5,16'hAAAA,0,0,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,2,1,6,16'hBBBB,0,0,0, 1,0,5,16'hAAAA,0,16'h0000));
    tv.push_back(mk(0,1,2,1,7,16'h7777,0,0,0, 0,0,5,16'hAAAA,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 0,1,5,16'hAAAA,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,1,6,16'hBBBB,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    // Forwarding: youngest of two r3 entries wins
    tv.push_back(mk(0,1,2,1,3,16'h0100,0,0,3, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,2,1,3,16'h0200,0,0,3, 1,0,3,16'h0100,1,16'h0100));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,0,3, 0,0,3,16'h0100,1,16'h0200));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,0,4, 0,0,3,16'h0100,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 0,1,3,16'h0100,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,1,3,16'h0200,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    // Non-writing entry retires silently and is not forwarded
    tv.push_back(mk(0,1,2,0,7,16'h1234,0,0,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,2,1,2,16'h5555,0,0,7, 1,0,7,16'h1234,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,7, 0,0,7,16'h1234,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,1,2,16'h5555,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));
    // Flush with a push offered: everything dropped
    tv.push_back(mk(0,1,2,1,1,16'h0011,0,0,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,2,1,2,16'h0022,0,0,0, 1,0,1,16'h0011,0,16'h0000));
    tv.push_back(mk(0,1,2,1,3,16'h0033,1,0,0, 0,0,1,16'h0011,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,3, 1,0,0,16'h0000,0,16'h0000));
    // Reset mid-operation
    tv.push_back(mk(0,1,2,1,1,16'h0044,0,0,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,1,2,1,2,16'h0055,0,0,2, 1,0,1,16'h0044,0,16'h0000));
    tv.push_back(mk(1,1,2,1,3,16'h0066,0,0,2, 0,0,1,16'h0044,1,16'h0055));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,2, 1,0,0,16'h0000,0,16'h0000));
    // Pop in a flush cycle still writes
    tv.push_back(mk(0,1,2,1,4,16'h0077,0,0,0, 1,0,0,16'h0000,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,1,1,0, 0,1,4,16'h0077,0,16'h0000));
    tv.push_back(mk(0,0,0,0,0,16'h0000,0,1,0, 1,0,0,16'h0000,0,16'h0000));

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].vld, tv[i].src, tv[i].wen, tv[i].wa, tv[i].val,
            tv[i].fl, tv[i].rfr, tv[i].fa);
      #1;
      chk($sformatf("vec%0d.in_ready", i), {31'b0, bus.in_ready}, {31'b0, tv[i].e_rdy});
      chk($sformatf("vec%0d.rf_wr_en", i), {31'b0, bus.rf_wr_en}, {31'b0, tv[i].e_wen});
      chk($sformatf("vec%0d.rf_wr_addr", i), {29'b0, bus.rf_wr_addr}, {29'b0, tv[i].e_wa});
      chk($sformatf("vec%0d.rf_wr_data", i), {16'b0, bus.rf_wr_data}, {16'b0, tv[i].e_wd});
      chk($sformatf("vec%0d.fwd_hit", i), {31'b0, bus.fwd_hit}, {31'b0, tv[i].e_hit});
      chk($sformatf("vec%0d.fwd_data", i), {16'b0, bus.fwd_data}, {16'b0, tv[i].e_fd});
      @(negedge clk);
    end

    // Randomized run against the queue model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(199) == 0), $urandom_range(1), 2'($urandom_range(3)),
            $urandom_range(1), 3'($urandom_range(7)), 16'($urandom),
            ($urandom_range(15) == 0), ($urandom_range(9) < 7), 3'($urandom_range(7)));
      cyc();
    end

    // Retire counter: five pops, then a flush on an empty buffer
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, (i < 5), 2, 1, 3'(i), 16'(i), 0, 1, 0);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef WB_RETIRE_CNT_EN
    chk("retire_five", {16'b0, bus.retire_cnt}, 32'd5);
`else
    chk("retire_tied", {16'b0, bus.retire_cnt}, 32'd0);
`endif
    drive(0, 1, 2, 1, 1, 16'h00AA, 1, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
`ifdef WB_RETIRE_CNT_EN
    chk("retire_after_flush", {16'b0, bus.retire_cnt}, 32'd5);
    begin
      int guard = 0;
      drive(0, 1, 1, 0, 2, 16'h0F0F, 0, 1, 2);
      while (mcnt != 16'hFFFF && guard < 70000) begin
        cyc();
        guard++;
      end
      if (guard >= 70000) chk("retire_wrap_timeout", 32'd1, 32'd0);
      #1;
      chk("retire_ffff", {16'b0, bus.retire_cnt}, 32'h0000FFFF);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("retire_wrap", {16'b0, bus.retire_cnt}, 32'h0);
    end
`else
    chk("retire_after_flush", {16'b0, bus.retire_cnt}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
